// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared types and helpers for the round-robin priority arbiter.
//
// Contents:
//   state_t  : arbiter FSM state (IDLE, GRANT)
//   num_req  : requester count N = 2**n for an encoded index width n
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Requester count for a given index width.
    function automatic int num_req(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/rr_prio_arbiter_if.sv
// rr_prio_arbiter_if -- request/grant bundle between clients and the arbiter.
//
// Parameter: n = encoded index width, N = 2**n requesters.
// Signals:
//   req       N  request vector, bit i = requester i wants the resource
//   ack       1  current grant consumed (only meaningful while gnt_valid=1)
//   gnt       N  one-hot grant, zero when idle
//   gnt_id    n  binary index of the granted requester
//   gnt_valid 1  a grant is active
// Modports:
//   master : client/resource side (drives req, ack)
//   slave  : arbiter side (drives gnt, gnt_id, gnt_valid)
//
// Handshake: a grant is presented while gnt_valid=1 and stays constant;
// it completes on the rising edge where gnt_valid=1 and ack=1. ack seen
// while gnt_valid=0 has no effect.
interface rr_prio_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int n = 3
) ();
    localparam int N = num_req(n);

    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] gnt;
    logic [n-1:0] gnt_id;
    logic         gnt_valid;

    modport master (
        output req,
        output ack,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    modport slave (
        input  req,
        input  ack,
        output gnt,
        output gnt_id,
        output gnt_valid
    );
endinterface

// File: rtl/rr_prio_enc.sv
// rr_prio_enc -- combinational rotating-priority 2^n-to-n encoder.
//
// Ports:
//   req   in  N  request vector
//   ptr   in  n  index that currently has highest priority
//   found out 1  at least one request is asserted
//   id    out n  first asserted index searching upward from ptr, wrapping
//
// The request vector is rotated so that ptr lands on bit 0, a fixed
// LSB-first encoder picks the winner, and ptr is added back (n-bit wrap).
module rr_prio_enc
    import rr_arb_pkg::*;
#(
    parameter int n = 3
) (
    input  logic [num_req(n)-1:0] req,
    input  logic [n-1:0]          ptr,
    output logic                  found,
    output logic [n-1:0]          id
);
    localparam int N = num_req(n);

    logic [N-1:0] rot;
    logic [n-1:0] off;
    logic [n-1:0] src;

    // rot[i] = req[(i + ptr) mod N]
    always_comb begin
        rot = '0;
        src = '0;
        for (int i = 0; i < N; i++) begin
            src    = i[n-1:0] + ptr;
            rot[i] = req[src];
        end
    end

    // Scan from the top down so the lowest asserted offset is written last.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = i[n-1:0];
            end
        end
        id = off + ptr;
    end

endmodule

// File: rtl/rr_prio_arbiter.sv
// rr_prio_arbiter -- registered round-robin arbiter over N = 2**n requesters.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   bus       slave modport of rr_prio_arbiter_if (req, ack -> gnt, gnt_id,
//             gnt_valid)
//   dbg_state out  current FSM state
//   dbg_ptr   out  current round-robin pointer (highest-priority index)
//
// Build option: define ARB_REQ_DROP_EN to abort a grant whose requester
// deasserts req before ack. Without it a grant is held until ack.
//
// All grant outputs come straight from flops; req only reaches them through
// the next-state logic. On an ack the pointer moves past the served
// requester and the encoder re-arbitrates in the same cycle, so back-to-back
// grants have no idle cycle between them.
module rr_prio_arbiter
    import rr_arb_pkg::*;
#(
    parameter int n = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_prio_arbiter_if.slave   bus,
    output state_t             dbg_state,
    output logic [n-1:0]       dbg_ptr
);
    localparam int N = num_req(n);

    state_t       state_q, state_d;
    logic [n-1:0] ptr_q,   ptr_d;
    logic [n-1:0] id_q,    id_d;
    logic [N-1:0] gnt_q,   gnt_d;
    logic         valid_q, valid_d;

    logic         served;
    logic         dropped;
    logic [n-1:0] after_id;
    logic [n-1:0] enc_ptr;
    logic         enc_found;
    logic [n-1:0] enc_id;

    // A grant is consumed only while one is active; stray ack is ignored.
    assign served   = (state_q == GRANT) && bus.ack;
    assign after_id = id_q + n'(1);

    // Re-arbitration after an ack must already use the advanced pointer.
    assign enc_ptr  = served ? after_id : ptr_q;

`ifdef ARB_REQ_DROP_EN
    // ack takes precedence over a simultaneous drop.
    assign dropped = (state_q == GRANT) && !bus.ack && !bus.req[id_q];
`else
    assign dropped = 1'b0;
`endif

    rr_prio_enc #(
        .n (n)
    ) u_enc (
        .req   (bus.req),
        .ptr   (enc_ptr),
        .found (enc_found),
        .id    (enc_id)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enc_found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (served) begin
                    state_d = enc_found ? GRANT : IDLE;
                end else if (dropped) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next grant outputs and pointer.
    always_comb begin
        ptr_d   = ptr_q;
        id_d    = id_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;

        // Whoever was just served (or aborted) drops to lowest priority.
        if (served || dropped) begin
            ptr_d = after_id;
        end

        if (((state_q == IDLE) || served) && enc_found) begin
            gnt_d         = '0;
            gnt_d[enc_id] = 1'b1;
            id_d          = enc_id;
            valid_d       = 1'b1;
        end else if ((served && !enc_found) || dropped) begin
            gnt_d   = '0;
            id_d    = '0;
            valid_d = 1'b0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;
    assign dbg_state     = state_q;
    assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// tb_rr_prio_arbiter -- self-checking bench for rr_prio_arbiter with n=2.
// Directed scenarios with fixed expected values, then randomized traffic
// checked against a queue-fed reference model.
module tb_rr_prio_arbiter;
    import rr_arb_pkg::*;

    localparam int n = 2;
    localparam int N = 4;
    localparam int W = 10;  // {gnt_valid, gnt_id, gnt, ptr, in_grant}

    logic         clk = 1'b0;
    logic         rst_n;
    state_t       dbg_state;
    logic [n-1:0] dbg_ptr;

    rr_prio_arbiter_if #(.n(n)) bus ();

    rr_prio_arbiter #(.n(n)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // ---------------- reference model ----------------
    // Abstract state: is someone granted, who, and where the search starts.
    bit m_valid = 0;
    int m_id    = 0;
    int m_ptr   = 0;

    function automatic int rr_search(input logic [3:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic r, input logic [3:0] q, input logic a);
        int w;
        if (!r) begin
            m_valid = 0; m_id = 0; m_ptr = 0;
        end else if (!m_valid) begin
            w = rr_search(q, m_ptr);
            if (w >= 0) begin m_valid = 1; m_id = w; end
        end else if (a) begin
            m_ptr = (m_id + 1) % N;
            w = rr_search(q, m_ptr);
            if (w >= 0) m_id = w;
            else begin m_valid = 0; m_id = 0; end
        end
`ifdef ARB_REQ_DROP_EN
        else if (!q[m_id]) begin
            m_ptr = (m_id + 1) % N; m_valid = 0; m_id = 0;
        end
`endif
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [3:0] g;
        logic [1:0] id2, p2;
        g   = m_valid ? (4'b0001 << m_id) : 4'b0000;
        id2 = m_id[1:0];
        p2  = m_ptr[1:0];
        return {m_valid, id2, g, p2, m_valid};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [3:0] q, input logic a);
        @(negedge clk);
        rst_n   = r;
        bus.req = q;
        bus.ack = a;
        model_step(r, q, a);
        exp_q.push_back(model_out());
    endtask

    // Directed spot check against hand-derived constants.
    task automatic spot(input string name, input logic v, input logic [1:0] id,
                        input logic [3:0] g, input logic [1:0] p, input logic st);
        logic [W-1:0] act, req_v;
        @(posedge clk);
        #2;
        act   = {bus.gnt_valid, bus.gnt_id, bus.gnt, dbg_ptr, (dbg_state == GRANT)};
        req_v = {v, id, g, p, st};
        n_vec++;
        if (act !== req_v) begin
            n_miss++;
            $display("FAIL %s: actual {valid,id,gnt,ptr,grant}=%b required=%b", name, act, req_v);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [W-1:0] act, e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bus.gnt_valid, bus.gnt_id, bus.gnt, dbg_ptr, (dbg_state == GRANT)};
            n_vec++;
            if (act !== e) begin
                n_miss++;
                $display("FAIL scoreboard cycle %0d: actual=%b required=%b", cyc, act, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] g;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.ack = 1'b0;

        // Reset held with all requests asserted, then released.
        drive(0, 4'b1111, 0); spot("rst_c0", 0, 0, 4'b0000, 0, 0);
        drive(0, 4'b1111, 0); spot("rst_c1", 0, 0, 4'b0000, 0, 0);
        drive(1, 4'b1111, 0); spot("rst_rel", 1, 0, 4'b0001, 0, 1);

        // Basic grant, back-to-back, wrap-around.
        drive(0, 4'b0000, 0);
        drive(1, 4'b0110, 0); spot("basic", 1, 1, 4'b0010, 0, 1);
        drive(1, 4'b0110, 1); spot("b2b", 1, 2, 4'b0100, 2, 1);
        drive(1, 4'b1001, 1); spot("wrap3", 1, 3, 4'b1000, 3, 1);
        drive(1, 4'b1001, 1); spot("wrap0", 1, 0, 4'b0001, 0, 1);

        // Fairness: all requesting, ack every cycle.
        drive(0, 4'b0000, 0);
        drive(1, 4'b1111, 0); spot("fair0", 1, 0, 4'b0001, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            g = 4'b0001 << (k % N);
            drive(1, 4'b1111, 1);
            spot("fair", 1, 2'(k % N), g, 2'(k % N), 1);
        end

        // Empty after ack, then stray ack while idle.
        drive(1, 4'b0000, 1); spot("empty", 0, 0, 4'b0000, 1, 0);
        drive(1, 4'b0000, 1); spot("stray", 0, 0, 4'b0000, 1, 0);

        // Request change while granted id=1.
        drive(1, 4'b0010, 0); spot("grant1", 1, 1, 4'b0010, 1, 1);
        drive(1, 4'b1000, 0);
`ifdef ARB_REQ_DROP_EN
        spot("drop", 0, 0, 4'b0000, 2, 0);
`else
        spot("hold", 1, 1, 4'b0010, 1, 1);
`endif
        drive(1, 4'b1000, 1); spot("after_hold", 1, 3, 4'b1000, 2, 1);

`ifdef ARB_REQ_DROP_EN
        // Drop moves the search start past the aborted requester.
        drive(0, 4'b0000, 0);
        drive(1, 4'b0010, 0); spot("drop_g1", 1, 1, 4'b0010, 0, 1);
        drive(1, 4'b1001, 0); spot("drop_clr", 0, 0, 4'b0000, 2, 0);
        drive(1, 4'b1001, 0); spot("drop_next", 1, 3, 4'b1000, 2, 1);
`endif

        // Reset during a grant discards the pending ack and pointer.
        drive(0, 4'b0000, 0);
        drive(1, 4'b0100, 0); spot("pre_rst", 1, 2, 4'b0100, 0, 1);
        drive(0, 4'b0100, 1); spot("mid_rst", 0, 0, 4'b0000, 0, 0);
        drive(1, 4'b0101, 0); spot("post_rst", 1, 0, 4'b0001, 0, 1);

        // Randomized traffic, scoreboard only.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end
        drive(1, 4'b0000, 1);
        drive(1, 4'b0000, 0);

        // Every expectation must have been consumed.
        repeat (3) @(posedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
